// File: rtl/ebs_sample_writer.sv
// EBS sample writer: captures event-based-sampling records into a small FIFO
// and streams each record as two 64-bit non-cacheable stores into a circular
// memory buffer feeding the cache subsystem's EBS store port.

package wt_cache_pkg;
  localparam int L1D_WAY_WIDTH  = 4;
  localparam int CACHE_ID_WIDTH = 2;

  typedef enum logic [1:0] {
    DCACHE_LOAD_REQ  = 2'd0,
    DCACHE_STORE_REQ = 2'd1,
    DCACHE_ATOP_REQ  = 2'd2,
    DCACHE_INT_REQ   = 2'd3
  } dcache_out_t;

  typedef struct packed {
    dcache_out_t                 rtype;
    logic [2:0]                  size;
    logic [L1D_WAY_WIDTH-1:0]    way_oh;
    logic [63:0]                 paddr;
    logic [63:0]                 data;
    logic                        nc;
    logic [CACHE_ID_WIDTH-1:0]   tid;
  } dcache_req_t;
endpackage

module ebs_sample_writer #(
  parameter int FifoDepth = 4,
  parameter int TxId      = 3,
  parameter int CntWidth  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      sample_trig_i,
  input  logic [63:0]               sample_pc_i,
  input  logic [63:0]               sample_miss_pc_i,
  input  logic [63:0]               buf_base_i,
  input  logic [15:0]               buf_words_i,
  output logic                      ebs_store_req_o,
  input  logic                      ebs_store_ack_i,
  output wt_cache_pkg::dcache_req_t ebs_store_data_o,
  output logic [15:0]               wr_ptr_o,
  output logic                      wrap_o,
  output logic [CntWidth-1:0]       drop_cnt_o,
  output logic                      busy_o
);

  localparam int AddrW = $clog2(FifoDepth);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_PC   = 2'd1,
    SEND_ADDR = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [127:0]       fifo_mem [FifoDepth];
  logic [AddrW:0]     fifo_wr_q, fifo_rd_q;
  logic               fifo_empty, fifo_full;
  logic               push, pop, xfer, capture;
  logic [63:0]        hold_pc_q, hold_miss_q;
  logic [15:0]        ptr_q, ptr_inc;
  logic               wrap_q;
  logic [CntWidth-1:0] drop_q;
  logic [63:0]        base_aligned;

  assign fifo_empty = (fifo_wr_q == fifo_rd_q);
  assign fifo_full  = (fifo_wr_q[AddrW] != fifo_rd_q[AddrW]) &&
                      (fifo_wr_q[AddrW-1:0] == fifo_rd_q[AddrW-1:0]);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign capture = sample_trig_i && enable_i;
  assign push    = capture && (!fifo_full || pop);
  assign xfer    = ebs_store_req_o && ebs_store_ack_i;
  assign ptr_inc = ptr_q + 16'd1;

  assign base_aligned = buf_base_i & ~64'h7;

  // Next-state logic: pop the head on entry to SEND_PC, chain records back to back.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND_PC;
        end
      end
      SEND_PC: begin
        if (ebs_store_ack_i) state_d = SEND_ADDR;
      end
      SEND_ADDR: begin
        if (ebs_store_ack_i) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SEND_PC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Sample storage; contents are only meaningful between the FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[fifo_wr_q[AddrW-1:0]] <= {sample_pc_i, sample_miss_pc_i};
  end

  // FIFO pointers, holding registers for the record in flight, drop counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      hold_pc_q   <= '0;
      hold_miss_q <= '0;
      drop_q      <= '0;
    end else begin
      if (push) fifo_wr_q <= fifo_wr_q + 1'b1;
      if (pop) begin
        fifo_rd_q                <= fifo_rd_q + 1'b1;
        {hold_pc_q, hold_miss_q} <= fifo_mem[fifo_rd_q[AddrW-1:0]];
      end
      if (capture && !push && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  // Circular write pointer; wraps to zero against the current buffer size.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (xfer) begin
        if (ptr_inc == buf_words_i) begin
          ptr_q  <= '0;
          wrap_q <= 1'b1;
        end else begin
          ptr_q <= ptr_inc;
        end
      end
    end
  end

  // Store packet; all fields stay zero while nothing is being offered.
  always_comb begin
    ebs_store_data_o = '0;
    if (state_q != IDLE) begin
      ebs_store_data_o.rtype  = wt_cache_pkg::DCACHE_STORE_REQ;
      ebs_store_data_o.size   = 3'b011;
      ebs_store_data_o.way_oh = '0;
      ebs_store_data_o.paddr  = base_aligned + {45'd0, ptr_q, 3'b000};
      ebs_store_data_o.data   = (state_q == SEND_PC) ? hold_pc_q : hold_miss_q;
      ebs_store_data_o.nc     = 1'b1;
      ebs_store_data_o.tid    = wt_cache_pkg::CACHE_ID_WIDTH'(TxId);
    end
  end

  assign ebs_store_req_o = (state_q != IDLE);
  assign wr_ptr_o        = ptr_q;
  assign wrap_o          = wrap_q;
  assign drop_cnt_o      = drop_q;
  assign busy_o          = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_ebs_sample_writer.sv
// Directed self-checking bench for ebs_sample_writer: single record, wrap,
// backpressure, overflow with same-cycle push/pop, disable drain, async reset.

module tb_ebs_sample_writer;

  logic                      clk_i = 1'b0;
  logic                      rst_i = 1'b1;
  logic                      enable_i = 1'b0;
  logic                      sample_trig_i = 1'b0;
  logic [63:0]               sample_pc_i = '0;
  logic [63:0]               sample_miss_pc_i = '0;
  logic [63:0]               buf_base_i = '0;
  logic [15:0]               buf_words_i = 16'd8;
  logic                      ebs_store_req_o;
  logic                      ebs_store_ack_i = 1'b0;
  wt_cache_pkg::dcache_req_t ebs_store_data_o;
  logic [15:0]               wr_ptr_o;
  logic                      wrap_o;
  logic [15:0]               drop_cnt_o;
  logic                      busy_o;

  int checks = 0;
  int errors = 0;

  ebs_sample_writer #(.FifoDepth(4), .TxId(3), .CntWidth(16)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .sample_trig_i    (sample_trig_i),
    .sample_pc_i      (sample_pc_i),
    .sample_miss_pc_i (sample_miss_pc_i),
    .buf_base_i       (buf_base_i),
    .buf_words_i      (buf_words_i),
    .ebs_store_req_o  (ebs_store_req_o),
    .ebs_store_ack_i  (ebs_store_ack_i),
    .ebs_store_data_o (ebs_store_data_o),
    .wr_ptr_o         (wr_ptr_o),
    .wrap_o           (wrap_o),
    .drop_cnt_o       (drop_cnt_o),
    .busy_o           (busy_o)
  );

  // 10-time-unit clock.
  always #5 clk_i = ~clk_i;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one sample trigger for one cycle; starts and ends on a falling edge.
  task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] miss);
    sample_trig_i    = 1'b1;
    sample_pc_i      = pc;
    sample_miss_pc_i = miss;
    @(negedge clk_i);
    sample_trig_i    = 1'b0;
  endtask

  // Wait for a request, check the packet, hold ack low 'hold' cycles, then ack once.
  task automatic do_store(input string tag, input logic [63:0] exp_addr, input logic [63:0] exp_data,
                          input int hold, input logic trig_on_ack, output logic wrap_seen);
    int n = 0;
    while (!ebs_store_req_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput($sformatf("%s req", tag), 64'(ebs_store_req_o), 64'd1);
    checkOutput($sformatf("%s paddr", tag), ebs_store_data_o.paddr, exp_addr);
    checkOutput($sformatf("%s data", tag), ebs_store_data_o.data, exp_data);
    checkOutput($sformatf("%s hdr", tag),
                {52'd0, 2'(ebs_store_data_o.rtype), ebs_store_data_o.size, ebs_store_data_o.way_oh,
                 ebs_store_data_o.nc, ebs_store_data_o.tid},
                {52'd0, 2'd1, 3'b011, 4'd0, 1'b1, 2'd3});
    for (int c = 0; c < hold; c++) begin
      @(negedge clk_i);
      checkOutput($sformatf("%s hold req", tag), 64'(ebs_store_req_o), 64'd1);
      checkOutput($sformatf("%s hold paddr", tag), ebs_store_data_o.paddr, exp_addr);
      checkOutput($sformatf("%s hold data", tag), ebs_store_data_o.data, exp_data);
    end
    ebs_store_ack_i = 1'b1;
    if (trig_on_ack) begin
      sample_trig_i    = 1'b1;
      sample_pc_i      = 64'h107;
      sample_miss_pc_i = 64'h207;
    end
    @(negedge clk_i);
    ebs_store_ack_i = 1'b0;
    sample_trig_i   = 1'b0;
    wrap_seen = wrap_o;
  endtask

  initial begin
    logic w;
    int si, id;
    logic [63:0] dat;
    logic [15:0] off;

    // Reset state.
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("rst req", 64'(ebs_store_req_o), 64'd0);
    checkOutput("rst wr_ptr", 64'(wr_ptr_o), 64'd0);
    checkOutput("rst drop", 64'(drop_cnt_o), 64'd0);
    checkOutput("rst busy", 64'(busy_o), 64'd0);
    checkOutput("rst wrap", 64'(wrap_o), 64'd0);
    checkOutput("rst pkt", ebs_store_data_o.paddr | ebs_store_data_o.data, 64'd0);
    rst_i       = 1'b0;
    enable_i    = 1'b1;
    buf_base_i  = 64'h8000_0000;
    buf_words_i = 16'd8;
    @(negedge clk_i);

    // Single sample with latency check: req two edges after the trigger.
    $display("[TB] single sample");
    applyStimulus(64'h1000, 64'h2000);
    checkOutput("lat T+1 req", 64'(ebs_store_req_o), 64'd0);
    checkOutput("lat T+1 busy", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    checkOutput("lat T+2 req", 64'(ebs_store_req_o), 64'd1);
    do_store("s1 w0", 64'h8000_0000, 64'h1000, 1, 1'b0, w);
    do_store("s1 w1", 64'h8000_0008, 64'h2000, 1, 1'b0, w);
    checkOutput("s1 wr_ptr", 64'(wr_ptr_o), 64'd2);
    checkOutput("s1 busy", 64'(busy_o), 64'd0);

    // Wrap with a 4-word buffer.
    $display("[TB] wrap");
    buf_words_i = 16'd4;
    applyStimulus(64'hA1, 64'hB1);
    applyStimulus(64'hA2, 64'hB2);
    do_store("wr w2", 64'h8000_0010, 64'hA1, 0, 1'b0, w);
    checkOutput("wr w2 wrap", 64'(w), 64'd0);
    do_store("wr w3", 64'h8000_0018, 64'hB1, 0, 1'b0, w);
    checkOutput("wr w3 wrap", 64'(w), 64'd1);
    checkOutput("wr w3 ptr", 64'(wr_ptr_o), 64'd0);
    do_store("wr w0", 64'h8000_0000, 64'hA2, 0, 1'b0, w);
    checkOutput("wr w0 wrap", 64'(w), 64'd0);
    do_store("wr w1", 64'h8000_0008, 64'hB2, 0, 1'b0, w);
    checkOutput("wr ptr", 64'(wr_ptr_o), 64'd2);

    // Backpressure; low base bits must be ignored.
    $display("[TB] backpressure");
    buf_words_i = 16'd8;
    buf_base_i  = 64'h8000_0007;
    applyStimulus(64'hC0, 64'hD0);
    do_store("bp w0", 64'h8000_0010, 64'hC0, 10, 1'b0, w);
    checkOutput("bp ptr", 64'(wr_ptr_o), 64'd3);
    do_store("bp w1", 64'h8000_0018, 64'hD0, 0, 1'b0, w);
    checkOutput("bp end ptr", 64'(wr_ptr_o), 64'd4);

    // Overflow: 7 back-to-back triggers, ack held low.
    $display("[TB] overflow");
    for (int i = 0; i < 7; i++) begin
      sample_trig_i    = 1'b1;
      sample_pc_i      = 64'h100 + 64'(i);
      sample_miss_pc_i = 64'h200 + 64'(i);
      @(negedge clk_i);
    end
    sample_trig_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ov drop", 64'(drop_cnt_o), 64'd2);
    checkOutput("ov busy", 64'(busy_o), 64'd1);
    // Word 1 ack coincides with a pop from the full FIFO: the extra push must land.
    for (int k = 0; k < 12; k++) begin
      si  = k / 2;
      id  = (si == 5) ? 7 : si;
      dat = ((k % 2) == 0) ? 64'h100 + 64'(id) : 64'h200 + 64'(id);
      off = 16'((4 + k) % 8);
      do_store($sformatf("ov w%0d", k), 64'h8000_0000 + {45'd0, off, 3'b000}, dat, 0, (k == 1), w);
      checkOutput($sformatf("ov w%0d wrap", k), 64'(w), (off == 16'd7) ? 64'd1 : 64'd0);
    end
    checkOutput("ov drop after", 64'(drop_cnt_o), 64'd2);
    checkOutput("ov ptr", 64'(wr_ptr_o), 64'd0);
    checkOutput("ov busy end", 64'(busy_o), 64'd0);

    // Disable during drain.
    $display("[TB] disable");
    applyStimulus(64'h300, 64'h400);
    applyStimulus(64'h301, 64'h401);
    enable_i = 1'b0;
    applyStimulus(64'h3FF, 64'h4FF);
    do_store("ds w0", 64'h8000_0000, 64'h300, 0, 1'b0, w);
    do_store("ds w1", 64'h8000_0008, 64'h400, 0, 1'b0, w);
    do_store("ds w2", 64'h8000_0010, 64'h301, 0, 1'b0, w);
    do_store("ds w3", 64'h8000_0018, 64'h401, 0, 1'b0, w);
    checkOutput("ds drop", 64'(drop_cnt_o), 64'd2);
    checkOutput("ds ptr", 64'(wr_ptr_o), 64'd4);
    repeat (5) @(negedge clk_i);
    checkOutput("ds req idle", 64'(ebs_store_req_o), 64'd0);
    checkOutput("ds busy idle", 64'(busy_o), 64'd0);

    // Reset in SEND_ADDR clears state between clock edges.
    $display("[TB] reset mid-transfer");
    enable_i = 1'b1;
    applyStimulus(64'h500, 64'h600);
    do_store("rs w0", 64'h8000_0020, 64'h500, 0, 1'b0, w);
    checkOutput("rs addr req", 64'(ebs_store_req_o), 64'd1);
    checkOutput("rs addr data", ebs_store_data_o.data, 64'h600);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("rs req", 64'(ebs_store_req_o), 64'd0);
    checkOutput("rs ptr", 64'(wr_ptr_o), 64'd0);
    checkOutput("rs drop", 64'(drop_cnt_o), 64'd0);
    checkOutput("rs busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);
    checkOutput("rs no store", 64'(ebs_store_req_o), 64'd0);
    checkOutput("rs ptr hold", 64'(wr_ptr_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ebs_sample_writer.md
Name: ebs_sample_writer

Overview:
- Producer side of the EBS store channel that `wt_cache_subsystem` accepts on `ebs_store_req_i`, `ebs_store_ack_o` and `ebs_store_data_i`.
- Captures event-based-sampling records and buffers them in a small sample FIFO.
- Serialises each record into 64-bit non-cacheable store packets, written into a circular memory buffer whose base and size come from CSRs.
- Sits beside the perf-counter logic and feeds the cache subsystem's EBS port.

Parameters:
- FifoDepth, 4, sample FIFO entries; power of two, at least 2.
- TxId, 3, transaction ID placed in every packet's tid field.
- CntWidth, 16, width of the dropped-sample counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- enable_i  in  1  sampling enable from CSR
- sample_trig_i  in  1  one-cycle sampling event
- sample_pc_i  in  64  PC captured on the event
- sample_miss_pc_i  in  64  `pc_dcache_miss_perf` value captured on the event
- buf_base_i  in  64  buffer base physical address; 8-byte aligned, bits [2:0] ignored
- buf_words_i  in  16  buffer size in 64-bit words; even, at least 2
- ebs_store_req_o  out  1  store request to the cache subsystem
- ebs_store_ack_i  in  1  store accepted
- ebs_store_data_o  out  wt_cache_pkg::dcache_req_t  store packet
- wr_ptr_o  out  16  word offset of the next write
- wrap_o  out  1  one-cycle pulse when wr_ptr_o wraps to 0
- drop_cnt_o  out  CntWidth  samples lost because the FIFO was full; saturates
- busy_o  out  1  FIFO non-empty or store outstanding

Behaviour:
- Reset values (async, active-high): all outputs 0, FIFO empty, FSM in IDLE, packet fields 0.
- Capture, on sample_trig_i && enable_i:
  - FIFO not full: push {sample_pc_i, sample_miss_pc_i}.
  - FIFO full: drop the sample and increment drop_cnt_o, saturating at all-ones.
  - A push and a pop in the same cycle when full: the push succeeds, i.e. full is evaluated after the pop.
- FSM states and transitions:
  - IDLE -> SEND_PC when the FIFO is non-empty; load the head entry into holding registers and pop it.
  - SEND_PC: ebs_store_req_o=1 with data = PC word. On ack, advance the pointer and go to SEND_ADDR.
  - SEND_ADDR: ebs_store_req_o=1 with data = miss-PC word. On ack, advance the pointer, then:
    - go to SEND_PC with the next entry loaded if the FIFO is non-empty;
    - otherwise go to IDLE.
- Handshake:
  - req is held high until ack is seen; the packet is stable while req is high.
  - The transfer completes in the cycle ack and req are both high.
  - The next packet is presented the following cycle.
  - An ack while req is low is ignored.
  - Latency: trigger at cycle T into an empty FIFO gives req at T+2 (capture at T+1, load at T+2).
- Packet fields:
  - rtype = DCACHE_STORE_REQ; size = 3'b011; nc = 1; tid = TxId; way_oh = 0.
  - paddr = {buf_base_i[63:3], 3'b000} + (wr_ptr << 3), 64-bit modulo.
  - data = 64-bit word.
- Pointer:
  - wr_ptr_o increments per acked word.
  - When the incremented value == buf_words_i, it becomes 0 and wrap_o pulses in the same cycle.
  - A buf_words_i change takes effect at the next comparison.
  - wr_ptr_o is not reset by enable_i.
- Disable:
  - Deasserting enable_i blocks new captures only.
  - Queued samples and the record in flight drain completely; a record is never split.
- Reset mid-transfer: state is cleared immediately; the partial record is lost; req drops asynchronously.
- busy_o = FIFO non-empty OR FSM != IDLE.

Test Plan:
- Single sample:
  - Stimulus: base=0x8000_0000, size=8, trigger pc=0x1000 / miss=0x2000, ack one cycle after each req.
  - Required: stores to 0x8000_0000 (data 0x1000) then 0x8000_0008 (data 0x2000); wr_ptr_o=2; busy_o falls.
- Wrap:
  - Stimulus: size=4, two samples.
  - Required: third word at offset 2, fourth at offset 3; wr_ptr_o returns to 0 with a wrap_o pulse on the fourth ack; a fifth word would go to base.
- Backpressure:
  - Stimulus: hold ack low 10 cycles.
  - Required: req and the packet stay stable all 10 cycles; one word completes on ack.
- Overflow:
  - Stimulus: ack stuck low, 7 triggers with FifoDepth=4.
  - Required: the first entry is popped into the holding registers, so 5 are held; drop_cnt_o=2; after ack released, 10 words are written in order.
- Disable during drain:
  - Stimulus: 2 samples queued, enable_i=0, one more trigger.
  - Required: 4 words written; the trigger is ignored with drop_cnt_o unchanged.
- Reset mid-transfer:
  - Stimulus: rst_i asserted during SEND_ADDR.
  - Required: req=0, wr_ptr_o=0 and drop_cnt_o=0 in the same cycle; no further stores.
